// File: rtl/data_mux_pkg.sv
// +----------------------------------------------------------------------------+
// | data_mux_pkg : shared mode encodings, channel indices, FSM states and      |
// |                slot-rotation helpers for data_multiplex / data_demultiplex |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package data_mux_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_REV  = 2'b10;
  localparam logic [1:0] MODE_FIX  = 2'b11;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH1 = 2'd0;
  localparam ch_idx_t CH2 = 2'd1;
  localparam ch_idx_t CH3 = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic ch_idx_t first_ch(input logic [1:0] m);
    return (m == MODE_REV) ? CH3 : CH1;
  endfunction

  function automatic ch_idx_t next_ch(input ch_idx_t c, input logic [1:0] m);
    ch_idx_t n;
    n = CH1;
    case (m)
      MODE_FWD: begin
        case (c)
          CH1:     n = CH2;
          CH2:     n = CH3;
          default: n = CH1;
        endcase
      end
      MODE_REV: begin
        case (c)
          CH3:     n = CH2;
          CH2:     n = CH1;
          default: n = CH3;
        endcase
      end
      default: n = CH1;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] ch_onehot(input ch_idx_t c);
    logic [2:0] v;
    case (c)
      CH1:     v = 3'b001;
      CH2:     v = 3'b010;
      CH3:     v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_counter.sv
// +----------------------------------------------------------------------------+
// | dwell_counter : per-slot dwell timer with frame load, clear and terminal   |
// |                 flag; the count is the 1-based index of the current cycle  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module dwell_counter
  import data_mux_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_advance,
  output logic             o_term,
  output logic             o_first
);

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_TWO = {{(CNT_W-2){1'b0}}, 2'b10};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_dwell_q;
  logic [CNT_W-1:0] w_eff;

  assign w_eff = (i_load_val == '0) ? c_ONE : i_load_val;

  // The load cycle is itself index 1, so a one-cycle dwell terminates at once.
  assign o_term  = i_load ? (w_eff == c_ONE) : (i_advance && (r_cnt == r_dwell_q));
  assign o_first = i_load || (i_advance && (r_cnt == c_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_dwell_q <= '0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_dwell_q <= '0;
    end else if (i_load) begin
      r_dwell_q <= w_eff;
      r_cnt     <= (w_eff == c_ONE) ? c_ONE : c_TWO;
    end else if (i_advance) begin
      r_cnt     <= o_term ? c_ONE : (r_cnt + c_ONE);
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_demultiplex.sv
// +----------------------------------------------------------------------------+
// | data_demultiplex : rebuilds DS1/DS2/DS3 from the TDM stream of            |
// |                    data_multiplex, aligned by frame_start.                |
// | Optional feature macro: DWELL_CHECK_EN (sticky dwell-stability error)     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_demultiplex
  import data_mux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  switch_clk_cycles,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] ch1_data,
  output logic [DATA_W-1:0] ch2_data,
  output logic [DATA_W-1:0] ch3_data,
  output logic [2:0]        ch_valid,
  output logic              active,
  output logic              sync_lost,
  output logic              dwell_err
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_mode_q;
  ch_idx_t    r_slot;

  logic       w_mode_change;
  logic       w_start;
  logic       w_advance;
  logic       w_capture;
  logic       w_term;
  logic       w_first;
  ch_idx_t    w_slot_cur;
  ch_idx_t    w_slot_nxt;
  logic [1:0] w_mode_eff;

  dwell_counter #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_mode_change),
    .i_load    (w_start),
    .i_load_val(switch_clk_cycles),
    .i_advance (w_advance),
    .o_term    (w_term),
    .o_first   (w_first)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_change = 1'b0;
    w_start       = 1'b0;
    w_advance     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start && (mode != MODE_HALT)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A mode change outranks a realigning frame_start.
        if (mode != r_mode_q) begin
          w_mode_change = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (frame_start && (mode != MODE_HALT)) begin
          w_start = 1'b1;
        end else begin
          w_advance = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_slot_cur = w_start ? first_ch(mode) : r_slot;
    w_mode_eff = w_start ? mode : r_mode_q;
    w_slot_nxt = next_ch(w_slot_cur, w_mode_eff);
    w_capture  = (w_start || w_advance) && w_term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= MODE_HALT;
      r_slot    <= CH1;
      ch1_data  <= '0;
      ch2_data  <= '0;
      ch3_data  <= '0;
      ch_valid  <= 3'b000;
      active    <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      ch_valid  <= 3'b000;
      sync_lost <= w_mode_change;
      active    <= (w_state_nxt == ST_RUN);
      if (w_start) r_mode_q <= mode;
      if (w_capture) begin
        case (w_slot_cur)
          CH1:     ch1_data <= in_data;
          CH2:     ch2_data <= in_data;
          default: ch3_data <= in_data;
        endcase
        ch_valid <= ch_onehot(w_slot_cur);
        r_slot   <= w_slot_nxt;
      end else if (w_start) begin
        r_slot <= w_slot_cur;
      end
    end
  end

`ifdef DWELL_CHECK_EN
  logic [DATA_W-1:0] r_ref;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref     <= '0;
      dwell_err <= 1'b0;
    end else if (w_first) begin
      r_ref <= in_data;
    end else if (w_advance && (in_data != r_ref)) begin
      dwell_err <= 1'b1;
    end
  end
`else
  logic w_unused_first;
  assign w_unused_first = w_first;
  assign dwell_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_demultiplex.sv
// +----------------------------------------------------------------------------+
// | tb_data_demultiplex : scoreboard bench for data_demultiplex               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_demultiplex;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [3:0] switch_clk_cycles;
  logic       frame_start;
  logic [7:0] in_data;
  logic [7:0] ch1_data, ch2_data, ch3_data;
  logic [2:0] ch_valid;
  logic       active, sync_lost, dwell_err;

  int checks = 0;
  int errors = 0;
  int pcnt   = 0;

`ifdef DWELL_CHECK_EN
  localparam logic c_EXP_ERR = 1'b1;
`else
  localparam logic c_EXP_ERR = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [2:0] vld;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  data_demultiplex #(.DATA_W(8), .CNT_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mode             (mode),
    .switch_clk_cycles(switch_clk_cycles),
    .frame_start      (frame_start),
    .in_data          (in_data),
    .ch1_data         (ch1_data),
    .ch2_data         (ch2_data),
    .ch3_data         (ch3_data),
    .ch_valid         (ch_valid),
    .active           (active),
    .sync_lost        (sync_lost),
    .dwell_err        (dwell_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pcnt <= pcnt + 1;

  // Strobe scoreboard: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] got;
    while (sb.size() > 0 && sb[0].cyc < pcnt) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_strobe: expected ch_valid=%b data=%h at cycle %0d, got no strobe", e.vld, e.data, e.cyc);
    end
    if (ch_valid !== 3'b000) begin
      checks++;
      got = (ch_valid == 3'b001) ? ch1_data : (ch_valid == 3'b010) ? ch2_data : ch3_data;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: ch_valid=%b data=%h at cycle %0d, required no strobe", ch_valid, got, pcnt);
      end else begin
        e = sb.pop_front();
        if (e.cyc != pcnt || e.vld !== ch_valid || e.data !== got) begin
          errors++;
          $display("FAIL strobe: got ch_valid=%b data=%h cycle %0d, required ch_valid=%b data=%h cycle %0d",
                   ch_valid, got, pcnt, e.vld, e.data, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] m, input logic [3:0] sw, input logic fs, input logic [7:0] d);
    @(negedge clk);
    mode = m; switch_clk_cycles = sw; frame_start = fs; in_data = d;
  endtask

  task automatic push_exp(input logic [2:0] v, input logic [7:0] d);
    sb.push_back('{pcnt + 1, v, d});
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mode = 2'b00; switch_clk_cycles = 4'd0; frame_start = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({ch1_data, ch2_data, ch3_data} !== 24'h0 || ch_valid !== 3'b000) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h v=%b, required 0", ch1_data, ch2_data, ch3_data, ch_valid);
    end
    checks++;
    if (active !== 1'b0 || sync_lost !== 1'b0 || dwell_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got a=%b s=%b e=%b, required 0", active, sync_lost, dwell_err);
    end
    rst_n = 1'b1;
    drive(2'b00, 4'd3, 1'b1, 8'h55);  // frame_start in halt is ignored
    drive(2'b00, 4'd3, 1'b0, 8'h55);
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL halt_ignore: active=%b, required 0", active); end
  endtask

  task automatic test_forward;
    logic [7:0] vals [4];
    logic [2:0] oh   [4];
    vals = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    oh   = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 24; i++) begin
      drive(2'b01, 4'd6, i == 0, vals[i / 6]);
      if (i % 6 == 5) push_exp(oh[i / 6], vals[i / 6]);
      if (i == 3) begin
        checks++;
        if (active !== 1'b1) begin errors++; $display("FAIL fwd_active: active=%b, required 1", active); end
      end
    end
    drive(2'b00, 4'd6, 1'b0, 8'h00);
    drive(2'b00, 4'd6, 1'b0, 8'h00);
    checks++;
    if (sync_lost !== 1'b1 || active !== 1'b0) begin
      errors++; $display("FAIL halt_sync_lost: got s=%b a=%b, required s=1 a=0", sync_lost, active);
    end
    drive(2'b00, 4'd6, 1'b0, 8'h00);
    checks++;
    if (sync_lost !== 1'b0) begin errors++; $display("FAIL sync_lost_pulse: got %b, required 0", sync_lost); end
    checks++;
    if (ch1_data !== 8'hDD || ch2_data !== 8'hBB || ch3_data !== 8'hCC) begin
      errors++; $display("FAIL fwd_hold: got %h/%h/%h, required dd/bb/cc", ch1_data, ch2_data, ch3_data);
    end
  endtask

  task automatic test_reverse;
    logic [7:0] vals [4];
    logic [2:0] oh   [4];
    vals = '{8'hCC, 8'hBB, 8'hAA, 8'h5C};
    oh   = '{3'b100, 3'b010, 3'b001, 3'b100};
    for (int i = 0; i < 12; i++) begin
      drive(2'b10, 4'd3, i == 0, vals[i / 3]);
      if (i % 3 == 2) push_exp(oh[i / 3], vals[i / 3]);
    end
    drive(2'b00, 4'd3, 1'b0, 8'h00);
    drive(2'b00, 4'd3, 1'b0, 8'h00);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rev_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_mode_change;
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 4'd4, i == 0, 8'h10 + 8'(i));
      if (i == 3) push_exp(3'b001, 8'h13);
    end
    drive(2'b10, 4'd4, 1'b0, 8'h16);
    drive(2'b10, 4'd4, 1'b0, 8'h17);
    checks++;
    if (sync_lost !== 1'b1 || active !== 1'b0) begin
      errors++; $display("FAIL mode_change: got s=%b a=%b, required s=1 a=0", sync_lost, active);
    end
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, 4'd4, 1'b0, 8'h20 + 8'(i));
      checks++;
      if (ch_valid !== 3'b000 || active !== 1'b0 || sync_lost !== 1'b0) begin
        errors++; $display("FAIL post_loss: got v=%b a=%b s=%b, required 0/0/0", ch_valid, active, sync_lost);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 4'd4, i == 0, 8'h30 + 8'(i));
      if (i == 3) push_exp(3'b100, 8'h33);
    end
    drive(2'b00, 4'd4, 1'b0, 8'h00);
    drive(2'b00, 4'd4, 1'b0, 8'h00);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL chg_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_fixed_dwell0;
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 4'd0, i == 0, vals[i]);
      push_exp(3'b001, vals[i]);
      if (i == 2) begin
        checks++;
        if (ch_valid !== 3'b001 || ch1_data !== 8'h22) begin
          errors++; $display("FAIL fixed_cont: got v=%b d=%h, required 001/22", ch_valid, ch1_data);
        end
      end
    end
    drive(2'b00, 4'd0, 1'b0, 8'h00);
    drive(2'b00, 4'd0, 1'b0, 8'h00);
  endtask

  task automatic test_realign;
    for (int i = 0; i < 3; i++) drive(2'b01, 4'd5, i == 0, 8'h50);
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 4'd5, i == 0, 8'h60);
      if (i == 4) push_exp(3'b001, 8'h60);
    end
    drive(2'b01, 4'd5, 1'b0, 8'h70);
    drive(2'b00, 4'd5, 1'b0, 8'h00);
    drive(2'b00, 4'd5, 1'b0, 8'h00);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL realign_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_dwell_max;
    for (int i = 0; i < 30; i++) begin
      drive(2'b01, 4'd15, i == 0, (i < 15) ? 8'h71 : 8'h72);
      if (i == 14) push_exp(3'b001, 8'h71);
      if (i == 29) push_exp(3'b010, 8'h72);
      if (i == 14) begin
        checks++;
        if (active !== 1'b1) begin errors++; $display("FAIL dwell15_active: active=%b, required 1", active); end
      end
    end
    drive(2'b00, 4'd15, 1'b0, 8'h00);
    drive(2'b00, 4'd15, 1'b0, 8'h00);
  endtask

  task automatic test_dwell_check;
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 4'd6, i == 0, (i < 3) ? 8'hAA : 8'hDD);
      if (i == 5) push_exp(3'b001, 8'hDD);
      if (i == 4) begin
        checks++;
        if (dwell_err !== c_EXP_ERR) begin errors++; $display("FAIL dwell_err_set: got %b, required %b", dwell_err, c_EXP_ERR); end
      end
    end
    drive(2'b00, 4'd6, 1'b0, 8'h00);
    drive(2'b00, 4'd6, 1'b0, 8'h00);
    checks++;
    if (dwell_err !== c_EXP_ERR) begin errors++; $display("FAIL dwell_err_sticky: got %b, required %b", dwell_err, c_EXP_ERR); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 4'd4, i == 0, (i < 4) ? 8'hA1 : 8'hB2);
      if (i == 3) push_exp(3'b001, 8'hA1);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ch1_data, ch2_data, ch3_data} !== 24'h0 || ch_valid !== 3'b000 || active !== 1'b0 || dwell_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h/%h/%h v=%b a=%b e=%b, required all 0",
                         ch1_data, ch2_data, ch3_data, ch_valid, active, dwell_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(2'b01, 4'd4, 1'b0, 8'hB2);
    checks++;
    if (active !== 1'b0 || ch2_data !== 8'h00) begin
      errors++; $display("FAIL post_reset: got a=%b ch2=%h, required 0/00", active, ch2_data);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_mode_change();
    test_fixed_dwell0();
    test_realign();
    test_dwell_max();
    test_dwell_check();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_drain: %0d pending, required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_demultiplex.md
Name: data_demultiplex

Overview:
- Receive-side stage directly downstream of data_multiplex.
- Consumes the 8-bit time-division stream (output_data) together with the same mode and switch_clk_cycles controls.
- Rebuilds the three source channels (DS1/DS2/DS3) into separate registered outputs, each with a one-cycle valid strobe.
- Alignment comes from a frame_start pulse; loss of alignment is reported.

Parameters:
- DATA_W, 8, width of stream and channel data.
- CNT_W, 4, width of switch_clk_cycles and the dwell counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  00 halt, 01 forward rotate 1->2->3->1, 10 reverse rotate 3->2->1->3, 11 fixed channel 1.
- switch_clk_cycles  input  CNT_W  dwell length per channel slot, in clocks; 0 is treated as 1.
- frame_start  input  1  one-cycle pulse coincident with the first cycle of the first slot of a frame.
- in_data  input  DATA_W  multiplexed stream (output_data of the upstream mux).
- ch1_data, ch2_data, ch3_data  output  DATA_W each  last captured value per channel.
- ch_valid  output  3  one-cycle strobe; bit0=ch1, bit1=ch2, bit2=ch3.
- active  output  1  high while in RUN.
- sync_lost  output  1  one-cycle pulse when RUN is aborted by a mode change.
- dwell_err  output  1  sticky dwell-stability error (optional feature only).

Behaviour:
- Reset (async assert, sync release): state IDLE; all chN_data = 0; ch_valid = 0; active = 0; sync_lost = 0; dwell_err = 0; internal counters = 0.
- States: IDLE, RUN.
- IDLE -> RUN: frame_start=1 and mode!=00.
  - Latch mode_q = mode and dwell_q = max(switch_clk_cycles, 1).
  - slot = first channel (01/11: ch1; 10: ch3); cnt = 1.
  - The frame_start cycle counts as cycle 1 of the first slot.
- RUN, each clock:
  - If mode != mode_q: go to IDLE, pulse sync_lost, no capture that cycle.
  - Else if frame_start=1 and mode!=00: realign exactly as IDLE->RUN; the partial dwell is discarded with no strobe.
  - Else if cnt == dwell_q:
    - At this edge, capture in_data into the slot's chN_data and set the slot's ch_valid bit for the next cycle only.
    - Advance slot per mode_q (mode 11 stays on ch1); cnt = 1.
  - Else cnt = cnt + 1. switch_clk_cycles changes mid-frame are ignored until the next frame_start.
- Latency: chN_data and the strobe appear in the cycle after the last dwell cycle of that slot.
- At most one ch_valid bit is high in any cycle.
- mode 00: frame_start is ignored. Entering 00 from RUN is a mode change, so sync_lost applies.
- active = (state == RUN), registered.
- Wrap-around: dwell_q = 15 counts fully, with no overflow (cnt never exceeds dwell_q).
- Reset mid-frame: immediate return to reset values. No strobe until the next frame_start.

Optional Feature:
- Macro DWELL_CHECK_EN.
- Defined:
  - Register the first-cycle value of each dwell.
  - If in_data differs from it on any later cycle of the same dwell, set dwell_err.
  - dwell_err is sticky until rst_n.
  - Capture and strobe still occur.
- Undefined: no compare logic; dwell_err tied 0.

Decomposition:
- Package data_mux_pkg:
  - Mode encodings (MODE_HALT, MODE_FWD, MODE_REV, MODE_FIX).
  - 2-bit channel-index typedef and constants CH1/CH2/CH3.
  - State enum.
  - Shared with data_multiplex.
- Sub-module dwell_counter:
  - Holds cnt/dwell_q with load (frame_start), clear, and terminal flag.
  - Reused by the mux for its switching timer.

Test Plan:
- Mode 01, dwell 6, stream AA x6, BB x6, CC x6, frame_start on the first AA cycle -> ch1=AA with ch_valid=001 on cycle 7, ch2=BB/010 on cycle 13, ch3=CC/100 on cycle 19, then ch1 again on cycle 25.
- Mode 10, dwell 3, stream CC x3, BB x3, AA x3 -> ch3=CC at cycle 4, ch2=BB at 7, ch1=AA at 10.
- Mode 01 running, mode switched to 10 mid-dwell -> sync_lost pulse the next cycle, active=0, no strobes until the next frame_start.
- switch_clk_cycles=0, mode 11, stream 11,22,33 -> ch1 updates every cycle with ch_valid=001 continuously (11, 22, 33).
- rst_n asserted mid-dwell with ch2 pending -> all outputs 0 immediately; after release, no strobe without frame_start.
- With DWELL_CHECK_EN, dwell 6, DD appears on cycle 4 of an AA dwell -> dwell_err=1 and stays 1; ch1 captures DD.
